// File: rtl/multicycle_processor.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/BRANCH/TRAP sequencing
// over one shared ALU, with a single unified memory port (req/ready handshake).
// Optional build macro PERF_CNT_EN adds cyc_cnt/inst_cnt performance counters.
module multicycle_processor #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       inst_cnt
`endif
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] br_tgt;
  logic [31:0]       ir;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [31:0]       alu_out;
  logic [31:0]       mdr;
  logic [31:0]       regs [32];

  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [31:0]       sext_imm;
  logic [31:0]       rf_a;
  logic [31:0]       rf_b;
  logic [31:0]       alu_res;
  logic              legal;
  logic              is_r;
  logic [ADDR_W-1:0] jmp_pc;
  logic [ADDR_W-1:0] br_sum;
  logic [27:0]       jfield;
  logic [4:0]        wb_dst;
  logic [31:0]       wb_val;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] x);
    return {x[ADDR_W-1:2], 2'b00};
  endfunction

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign rf_a     = (rs == 5'd0) ? '0 : regs[rs];
  assign rf_b     = (rt == 5'd0) ? '0 : regs[rt];
  assign is_r     = (op == OP_R);
  assign jfield   = {ir[25:0], 2'b00};
  assign br_sum   = pc + (ADDR_W'($signed(sext_imm)) << 2);
  assign wb_dst   = is_r ? rd : rt;
  assign wb_val   = (op == OP_LW) ? mdr : alu_out;
  assign dbg_pc   = pc;

  // Opcode/funct legality check used by DECODE to divert to TRAP.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
          default:                          legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
  end

  // Shared ALU: register-register ops for R-type, base+offset otherwise.
  always_comb begin
    alu_res = '0;
    if (is_r) begin
      case (funct)
        F_ADD:   alu_res = a + b;
        F_SUB:   alu_res = a - b;
        F_AND:   alu_res = a & b;
        F_OR:    alu_res = a | b;
        F_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = '0;
      endcase
    end else begin
      alu_res = a + sext_imm;
    end
  end

  // Jump target: low 28 bits come from the instruction, upper PC bits kept;
  // bits that do not exist at narrow ADDR_W are simply dropped.
  always_comb begin
    jmp_pc = pc;
    for (int unsigned i = 0; i < 28; i++) begin
      if (i < ADDR_W) jmp_pc[i] = jfield[i];
    end
  end

  // Main control FSM with registered memory-port, retire and halt outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      br_tgt    <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          // mem_req is only low here on the first cycle out of reset;
          // every other entry into FETCH already issued the request.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_align(pc);
          end else if (mem_ready) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(4);
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a      <= rf_a;
          b      <= rf_b;
          br_tgt <= br_sum;
          if (!legal) begin
            halted <= 1'b1;
            state  <= S_TRAP;
          end else if (op == OP_J) begin
            pc       <= jmp_pc;
            retire   <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_align(jmp_pc);
            state    <= S_FETCH;
          end else if (op == OP_BEQ) begin
            state <= S_BRANCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_BRANCH: begin
          retire   <= 1'b1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          state    <= S_FETCH;
          if (a == b) begin
            pc       <= br_tgt;
            mem_addr <= word_align(br_tgt);
          end else begin
            mem_addr <= word_align(pc);
          end
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (op == OP_LW || op == OP_SW) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_SW);
            mem_addr  <= word_align(ADDR_W'(alu_res));
            mem_wdata <= b;
            state     <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            if (op == OP_SW) begin
              // Store completion hands straight over to the next fetch request.
              retire   <= 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= word_align(pc);
              state    <= S_FETCH;
            end else begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) regs[wb_dst] <= wb_val;
          retire   <= 1'b1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= word_align(pc);
          state    <= S_FETCH;
        end
        S_TRAP: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Cycle and retired-instruction counters, both free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      if (!halted) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire)  inst_cnt <= inst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_processor.sv
// Self-checking bench for multicycle_processor: an instruction-level reference
// model predicts memory transactions, retire latencies and final register state.
module tb_multicycle_processor;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        retire;
  logic        halted;
  logic [31:0] dbg_pc;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] inst_cnt;
`endif

  multicycle_processor #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retire    (retire),
    .halted    (halted),
    .dbg_pc    (dbg_pc)
`ifdef PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .inst_cnt  (inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  int checks = 0;
  int errors = 0;

  // Memory model / monitor state
  logic [31:0] mem [256];
  int          wait_n = 0;
  int          cnt = 0;
  int          cyc = 0;
  int          f0 = -1;
  int          req_halt = 0;
  int          stab_err = 0;
  int          wr_cnt = 0;
  bit          pend = 0;
  logic [31:0] h_addr, h_wd;
  logic        h_we;
  int          rt_q[$];
  tx_t         dut_tx[$];

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  tx_t         exp_tx[$];
  int          exp_lat[$];
  logic [31:0] prog[$];

  // Completion, stability and write tracking on the active edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      cnt  = 0;
      pend = 0;
    end else begin
      if (pend && (!mem_req || mem_addr !== h_addr || mem_we !== h_we ||
                   (mem_we && mem_wdata !== h_wd)))
        stab_err++;
      if (mem_req && mem_ready) begin
        dut_tx.push_back({mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          wr_cnt++;
        end
        cnt  = 0;
        pend = 0;
      end else begin
        if (mem_req) cnt++;
        pend   = mem_req;
        h_addr = mem_addr;
        h_we   = mem_we;
        h_wd   = mem_wdata;
      end
    end
  end

  // Drive ready/rdata and observe outputs away from the active edge.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ready = 1'b0;
    end else begin
      mem_ready = (cnt >= wait_n);
      mem_rdata = mem[mem_addr[9:2]];
    end
    if (!rst) begin
      if (retire) rt_q.push_back(cyc);
      if (mem_req && f0 < 0) f0 = cyc;
      if (halted && mem_req) req_halt++;
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] f, input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    logic [4:0]  s, t;
    logic [15:0] im;
    s = rs[4:0]; t = rt[4:0]; im = imm[15:0];
    return {op, s, t, im};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    logic [25:0] t;
    t = tgt[25:0];
    return {6'h02, t};
  endfunction

  function automatic void m_wr(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0) m_reg[idx] = v;
  endfunction

  // Instruction-level reference: runs until the first illegal instruction.
  function automatic void model_run(input int w);
    logic [31:0] ins, ra, rb, simm, ea, pc;
    exp_tx.delete();
    exp_lat.delete();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    pc = RPC;
    for (int n = 0; n < 500; n++) begin
      ins = m_mem[pc[9:2]];
      exp_tx.push_back({1'b0, pc, ins});
      pc   = pc + 32'd4;
      m_pc = pc;
      ra   = m_reg[ins[25:21]];
      rb   = m_reg[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20: m_wr(ins[15:11], ra + rb);
            6'h22: m_wr(ins[15:11], ra - rb);
            6'h24: m_wr(ins[15:11], ra & rb);
            6'h25: m_wr(ins[15:11], ra | rb);
            6'h2A: m_wr(ins[15:11], ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0);
            default: return;
          endcase
          exp_lat.push_back(4 + w);
        end
        6'h08: begin
          m_wr(ins[20:16], ra + simm);
          exp_lat.push_back(4 + w);
        end
        6'h23: begin
          ea = (ra + simm) & ~32'd3;
          exp_tx.push_back({1'b0, ea, m_mem[ea[9:2]]});
          m_wr(ins[20:16], m_mem[ea[9:2]]);
          exp_lat.push_back(5 + 2 * w);
        end
        6'h2B: begin
          ea = (ra + simm) & ~32'd3;
          exp_tx.push_back({1'b1, ea, rb});
          m_mem[ea[9:2]] = rb;
          exp_lat.push_back(4 + 2 * w);
        end
        6'h04: begin
          if (ra == rb) pc = pc + (simm << 2);
          m_pc = pc;
          exp_lat.push_back(3 + w);
        end
        6'h02: begin
          pc   = {pc[31:28], ins[25:0], 2'b00};
          m_pc = pc;
          exp_lat.push_back(2 + w);
        end
        default: return;
      endcase
    end
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < prog.size(); i++) mem[(RPC >> 2) + i] = prog[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    rt_q.delete();
    dut_tx.delete();
    f0 = -1;
    req_halt = 0;
    stab_err = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_mem_req", mem_req, 1);
    check("post_rst_mem_addr", mem_addr, RPC);
    check("post_rst_mem_we", mem_we, 0);
    check("post_rst_retire", retire, 0);
    check("post_rst_halted", halted, 0);
  endtask

  task automatic wait_halt_and_check(input string ph);
    int prev;
    for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
    check({ph, "_halt_reached"}, halted, 1);
    repeat (6) @(negedge clk);
    check({ph, "_halted"}, halted, 1);
    check({ph, "_retire_count"}, rt_q.size(), exp_lat.size());
    for (int k = 0; k < rt_q.size() && k < exp_lat.size(); k++) begin
      prev = (k == 0) ? f0 : rt_q[k-1];
      check($sformatf("%s_latency[%0d]", ph, k), rt_q[k] - prev, exp_lat[k]);
    end
    check({ph, "_tx_count"}, dut_tx.size(), exp_tx.size());
    for (int k = 0; k < dut_tx.size() && k < exp_tx.size(); k++)
      check($sformatf("%s_tx[%0d]", ph, k), dut_tx[k], exp_tx[k]);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_reg[%0d]", ph, r), dut.regs[r], m_reg[r]);
    check({ph, "_dbg_pc"}, dbg_pc, m_pc);
    check({ph, "_req_after_halt"}, req_halt, 0);
    check({ph, "_stable"}, stab_err, 0);
`ifdef PERF_CNT_EN
    check({ph, "_inst_cnt"}, inst_cnt, rt_q.size());
`endif
  endtask

  task automatic run_prog(input string ph, input int w);
    wait_n = w;
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    model_run(w);
    @(negedge clk);
    do_reset();
    wait_halt_and_check(ph);
  endtask

  initial begin
    logic [5:0] fn [5];
    int k, wr_before;
    bit hit;
    fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    // ALU sequence, zero wait states
    prog = '{enc_i(6'h08, 1, 0, 5), enc_i(6'h08, 2, 0, -3), enc_r(6'h20, 3, 1, 2),
             enc_r(6'h2A, 4, 2, 1), enc_r(6'h22, 5, 2, 1), enc_i(6'h08, 0, 0, 7),
             32'hFC00_0000};
    load_prog();
    run_prog("alu", 0);
    check("alu_r3", dut.regs[3], 32'd2);
    check("alu_r4", dut.regs[4], 32'd1);
    check("alu_r5", dut.regs[5], 32'hFFFF_FFF8);
    check("alu_r0", dut.regs[0], 32'd0);

    // Store/load with 3 wait states per access
    prog = '{enc_i(6'h08, 3, 0, 2), enc_i(6'h2B, 3, 0, 8), enc_i(6'h23, 6, 0, 8),
             32'hFC00_0000};
    load_prog();
    run_prog("mem", 3);
    check("mem_r6", dut.regs[6], 32'd2);
    check("mem_word8", mem[2], 32'd2);
    if (rt_q.size() >= 3) check("mem_lw_latency", rt_q[2] - rt_q[1], 11);
    else check("mem_lw_latency_present", rt_q.size(), 3);

    // Branch and jump
    prog = '{enc_i(6'h08, 1, 0, 5), enc_i(6'h08, 2, 0, 6), enc_i(6'h04, 1, 1, 2),
             enc_i(6'h08, 7, 0, 1), enc_i(6'h08, 7, 0, 2), enc_i(6'h04, 2, 1, 2),
             enc_i(6'h08, 8, 0, 3), enc_j(32'h40), enc_i(6'h08, 9, 0, 4)};
    load_prog();
    mem[32'h100 >> 2] = enc_i(6'h08, 10, 0, 11);
    mem[32'h104 >> 2] = 32'hFC00_0000;
    run_prog("branch", 1);
    check("branch_r7_skipped", dut.regs[7], 32'd0);
    check("branch_r8", dut.regs[8], 32'd3);
    check("branch_r10", dut.regs[10], 32'd11);

    // Randomized ALU/memory programs against the reference model
    for (int p = 0; p < 4; p++) begin
      prog.delete();
      for (int i = 0; i < 14; i++) begin
        k = $urandom_range(0, 7);
        if (k < 5)
          prog.push_back(enc_r(fn[k], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        else if (k == 5)
          prog.push_back(enc_i(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
        else
          prog.push_back(enc_i((k == 6) ? 6'h23 : 6'h2B, $urandom_range(0, 7), 0,
                               32'h200 + 4 * $urandom_range(0, 15)));
      end
      prog.push_back((p % 2 == 0) ? 32'hFC00_0000 : enc_r(6'h3F, 1, 1, 1));
      load_prog();
      for (int i = 32'h200 >> 2; i < (32'h240 >> 2); i++) mem[i] = $urandom;
      run_prog($sformatf("rand%0d", p), $urandom_range(0, 2));
    end

    // Reset during a store's wait states
    prog = '{enc_i(6'h08, 3, 0, 9), enc_i(6'h2B, 3, 0, 16), 32'hFC00_0000};
    load_prog();
    wait_n = 3;
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    model_run(3);
    @(negedge clk);
    do_reset();
    wr_before = wr_cnt;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (mem_req && mem_we && mem_ready) begin
        hit = 1;
        break;
      end
    end
    check("midmem_store_seen", hit, 1);
    do_reset();
    check("midmem_no_store", wr_cnt - wr_before, 0);
    check("midmem_word16", mem[4], 32'd0);
    wait_halt_and_check("midmem");
    check("midmem_final_word16", mem[4], 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
